arm_hazard_unit: RTL
====================

// Module: arm_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage ARM pipeline (F,D,E,M,W).
//  Tracks in-flight destination tags for E/M/W internally and drives forward selects, stalls and flushes.
//  Replaces the hardwired ForwardAE/BE=0 and pipeEnable/pcEnable=1 ties.
//  Adds saturating stall/flush performance counters.
// PARAMETERS
//  RA_W      4   register address width
//  PC_REG    15  PC register index; never forwarded, never a RAW source
//  FWD_EN    1   1: forward from M/W; 0: stall-only mode, all Forward* = 00
//  CNT_W     16  perf counter width, saturating
// PORTS
//  clk          in   1     clock
//  reset        in   1     asynchronous, active-high
//  validD       in   1     D-stage register holds a real instruction
//  RA1D/RA2D/RA3D in RA_W  D-stage source regs (Rn, Rm, Rs/Rd-store)
//  UseD         in   3     per-source use bits {3,2,1}
//  WA3D         in   RA_W  D-stage destination reg
//  RegWriteD    in   1     D writes register file
//  MemToRegD    in   1     D is a load
//  PCSrcD       in   1     D writes PC (R15 dest or branch-to-reg)
//  BranchTakenE in   1     E-stage branch resolved taken
//  ForwardAE/BE/CE out 2   00 regfile, 01 ResultW, 10 ALUOutM
//  StallF       out  1     hold PC
//  StallD       out  1     hold F/D pipe register
//  FlushD       out  1     bubble F/D register
//  FlushE       out  1     bubble D/E register
//  StallCnt     out  CNT_W cycles with StallD=1
//  FlushCnt     out  CNT_W cycles with FlushE=1
// BEHAVIOUR
//  - Tag regs per stage E,M,W: {v,rw,m2r,pcs,dst}; E also {src1..3,use}. Reset clears all to 0, counters to 0.
//  - Every clk: W<=M, M<=E; E<=bubble(all 0) if FlushE or !validD, else D fields. No stage holds; stalls insert E bubbles.
//  - Hit(stage,s): stage.v & stage.rw & stage.dst==s & s!=PC_REG & use(s).
//  - Forward (combinational, E sources): Hit(M)->10, else Hit(W)->01, else 00; M beats W on double hit. FWD_EN=0 -> 00.
//  - LoadStall: FWD_EN=1: E.m2r & Hit(E, any used D source).
//    FWD_EN=0: Hit(E or M, any used D source). The regfile writes in the first half-cycle, so W never stalls.
//  - PCPend: validD&PCSrcD | E.pcs | M.pcs (W writes PC this cycle; no wait).
//  - StallD = LoadStall; StallF = LoadStall | PCPend.
//  - FlushE = LoadStall | BranchTakenE; FlushD = PCPend | BranchTakenE.
//  - Priority: BranchTakenE forces StallF=StallD=0 (PC takes target, D/E squashed), regardless of LoadStall/PCPend.
//  - PCPend with LoadStall: both apply. The stall holds D, and FlushD is suppressed while StallD=1.
//  - Counters increment by 1 per qualifying cycle. They hold at 2^CNT_W-1 with no wrap.
//  - Reset (any time, async): tags cleared immediately and all outputs 0/00 that same cycle. In-flight hazards are discarded.
//  - Latency: outputs are combinational from tag regs + D inputs. No extra cycle.
// TESTING
//  1. ADD R1 (E), then SUB uses R1 -> ForwardAE=10 next cycle. One cycle later a dependent op -> 01.
//  2. LDR R2 in E, D uses R2 -> StallF=StallD=FlushE=1 for exactly 1 cycle; then ForwardBE=01. StallCnt=1.
//  3. D has PCSrcD=1 -> StallF=FlushD=1 for 3 cycles (D,E,M), then clear. FlushCnt unchanged.
//  4. BranchTakenE=1 during LoadStall -> StallF=StallD=0, FlushD=FlushE=1. Next cycle E tag is a bubble.
//  5. FWD_EN=0: ADD R3, then dependent ORR -> StallD=1 for 2 cycles, Forward*=00 throughout.
//  6. CNT_W=2: 5 stall cycles -> StallCnt=3. Assert reset mid-load-stall -> all outputs 0 same cycle, counters 0.

Source files
------------

// File: rtl/arm_hazard_unit.sv
// Hazard/forwarding controller for a 5-stage ARM pipeline (F,D,E,M,W).
// Latency: all controls are combinational from the E/M/W tag registers and the D inputs.
// Backpressure: a load-use (or any RAW in stall-only mode) holds F/D and bubbles E; a pending PC write holds F.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   validD, RA1D/RA2D/RA3D      D-stage valid and source registers (Rn, Rm, Rs/Rd-store)
//   UseD                        per-source use bits {src3, src2, src1}
//   WA3D, RegWriteD, MemToRegD  D-stage destination, register write, load
//   PCSrcD                      D writes the PC
//   BranchTakenE                E-stage branch resolved taken
//   ForwardAE/BE/CE             00 regfile, 01 ResultW, 10 ALUOutM
//   StallF, StallD, FlushD, FlushE
//   StallCnt, FlushCnt          saturating counts of StallD / FlushE cycles
module arm_hazard_unit #(
    parameter int RA_W   = 4,
    parameter int PC_REG = 15,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validD,
    input  logic [RA_W-1:0]  RA1D,
    input  logic [RA_W-1:0]  RA2D,
    input  logic [RA_W-1:0]  RA3D,
    input  logic [2:0]       UseD,
    input  logic [RA_W-1:0]  WA3D,
    input  logic             RegWriteD,
    input  logic             MemToRegD,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [1:0]       ForwardCE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

    // E needs its sources for forwarding. M keeps only what forwarding and PC
    // tracking read, and W only what forwarding reads; the load flag is not
    // needed past E because a load consumer can never reach E while the load is in M.
    typedef struct packed {
        logic            v;
        logic            rw;
        logic            m2r;
        logic            pcs;
        logic [RA_W-1:0] dst;
        logic [RA_W-1:0] src1;
        logic [RA_W-1:0] src2;
        logic [RA_W-1:0] src3;
        logic [2:0]      use_bits;
    } e_tag_t;

    typedef struct packed {
        logic            v;
        logic            rw;
        logic            pcs;
        logic [RA_W-1:0] dst;
    } m_tag_t;

    typedef struct packed {
        logic            v;
        logic            rw;
        logic [RA_W-1:0] dst;
    } w_tag_t;

    e_tag_t e_q, e_d;
    m_tag_t m_q, m_d;
    w_tag_t w_q, w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic d_hit_e, d_hit_m, load_stall, pc_pend;
    logic hold_fetch, hold_dec, bubble_dec, bubble_ex;

    // The PC is never a RAW source, so writes to it never forward or stall.
    function automatic logic hit(input logic v, input logic rw, input logic [RA_W-1:0] dst,
                                 input logic [RA_W-1:0] s, input logic u);
        return v & rw & (dst == s) & (s != PC_IDX) & u;
    endfunction

    // M is the younger producer, so it wins over W on a double hit.
    function automatic logic [1:0] fwd_sel(input m_tag_t m, input w_tag_t w,
                                           input logic [RA_W-1:0] s, input logic u);
        logic [1:0] sel;
        sel = 2'b00;
        if (FWD_EN) begin
            if (hit(m.v, m.rw, m.dst, s, u))      sel = 2'b10;
            else if (hit(w.v, w.rw, w.dst, s, u)) sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        d_hit_e = validD & (hit(e_q.v, e_q.rw, e_q.dst, RA1D, UseD[0]) |
                            hit(e_q.v, e_q.rw, e_q.dst, RA2D, UseD[1]) |
                            hit(e_q.v, e_q.rw, e_q.dst, RA3D, UseD[2]));
        d_hit_m = validD & (hit(m_q.v, m_q.rw, m_q.dst, RA1D, UseD[0]) |
                            hit(m_q.v, m_q.rw, m_q.dst, RA2D, UseD[1]) |
                            hit(m_q.v, m_q.rw, m_q.dst, RA3D, UseD[2]));

        // Without forwarding a consumer waits until its producer reaches W;
        // the regfile writes in the first half-cycle so W itself never stalls.
        load_stall = FWD_EN ? (e_q.m2r & d_hit_e) : (d_hit_e | d_hit_m);
        pc_pend    = (validD & PCSrcD) | e_q.pcs | m_q.pcs;

        // A taken branch redirects the PC and squashes D/E, overriding any hold.
        hold_dec   = load_stall & ~BranchTakenE;
        hold_fetch = (load_stall | pc_pend) & ~BranchTakenE;
        bubble_ex  = load_stall | BranchTakenE;
        // A held D register must not also be bubbled.
        bubble_dec = (pc_pend | BranchTakenE) & ~hold_dec;

        e_d = '0;
        if (validD && !bubble_ex) begin
            e_d.v        = 1'b1;
            e_d.rw       = RegWriteD;
            e_d.m2r      = MemToRegD;
            e_d.pcs      = PCSrcD;
            e_d.dst      = WA3D;
            e_d.src1     = RA1D;
            e_d.src2     = RA2D;
            e_d.src3     = RA3D;
            e_d.use_bits = UseD;
        end
        m_d = {e_q.v, e_q.rw, e_q.pcs, e_q.dst};
        w_d = {m_q.v, m_q.rw, m_q.dst};

        stall_cnt_d = stall_cnt_q;
        if (hold_dec && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (bubble_ex && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset forces every control low in the same cycle, even though the D
    // inputs alone could otherwise still raise a PC hold or branch flush.
    assign ForwardAE = reset ? 2'b00 : fwd_sel(m_q, w_q, e_q.src1, e_q.use_bits[0]);
    assign ForwardBE = reset ? 2'b00 : fwd_sel(m_q, w_q, e_q.src2, e_q.use_bits[1]);
    assign ForwardCE = reset ? 2'b00 : fwd_sel(m_q, w_q, e_q.src3, e_q.use_bits[2]);
    assign StallF    = hold_fetch & ~reset;
    assign StallD    = hold_dec   & ~reset;
    assign FlushD    = bubble_dec & ~reset;
    assign FlushE    = bubble_ex  & ~reset;
    assign StallCnt  = stall_cnt_q;
    assign FlushCnt  = flush_cnt_q;

endmodule
